control_pipe: RTL and testbench

CONTROL_PIPE -- requirements
Module: control_pipe

---
 rtl/control_pkg.sv | 18 +
 rtl/control_pipe_stage.sv | 47 ++++
 rtl/control_pipe.sv | 103 ++++++++++
 tb/tb_control_pipe.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared helpers for control_pipe: occupancy counter width and even parity.
`timescale 1ns/1ps

package control_pkg;

    // Widest word the parity helper handles; callers zero-extend into it.
    localparam int unsigned PARITY_MAX_W = 256;

    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Zero padding does not change the XOR reduction.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/control_pipe_stage.sv
// One pipeline stage: a data register plus a valid flag, loaded whenever the stage can advance.
`timescale 1ns/1ps

module control_pipe_stage #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         load_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Data only moves with a real word so a stalled or emptied stage keeps its value.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/control_pipe.sv
// Valid/ready register pipeline of DEPTH stages with collapsing bubbles and flush.
// Optional stored even parity per word: define CONTROL_PIPE_PARITY_EN.
`timescale 1ns/1ps

module control_pipe
    import control_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned OCC_W = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [OCC_W-1:0] occupancy,
    output logic             out_perr
);

`ifdef CONTROL_PIPE_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif
    localparam int unsigned SW = WIDTH + PAR_W;

    logic [DEPTH-1:0] vld;
    logic [SW-1:0]    dat [DEPTH];
    logic [DEPTH:0]   rdy;
    logic             accept;
    logic [SW-1:0]    in_word;

    // rdy[k]: stage k may load this edge (empty, or its word moves on).
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rdy[DEPTH-1-i] = ~vld[DEPTH-1-i] | rdy[DEPTH-i];
        end
    end

    assign in_ready = rst_n & ~flush & rdy[0];
    assign accept   = in_valid & in_ready;

`ifdef CONTROL_PIPE_PARITY_EN
    logic [PARITY_MAX_W-1:0] in_ext, out_ext;

    always_comb begin
        in_ext                = '0;
        in_ext[WIDTH-1:0]     = in_data;
        out_ext               = '0;
        out_ext[WIDTH-1:0]    = dat[DEPTH-1][WIDTH-1:0];
    end

    assign in_word  = {even_parity(in_ext), in_data};
    assign out_perr = vld[DEPTH-1] & (dat[DEPTH-1][WIDTH] != even_parity(out_ext));
`else
    assign in_word  = in_data;
    assign out_perr = 1'b0;
`endif

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic          v_in;
        logic [SW-1:0] d_in;

        if (k == 0) begin : g_head
            assign v_in = accept;
            assign d_in = in_word;
        end else begin : g_body
            assign v_in = vld[k-1];
            assign d_in = dat[k-1];
        end

        control_pipe_stage #(
            .W (SW)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush_i (flush),
            .load_i  (rdy[k]),
            .valid_i (v_in),
            .data_i  (d_in),
            .valid_o (vld[k]),
            .data_o  (dat[k])
        );
    end

    always_comb begin
        occupancy = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(vld[i]);
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1][WIDTH-1:0];

endmodule

// File: tb/tb_control_pipe.sv
// Scoreboard bench for control_pipe (WIDTH=8, DEPTH=3).
`timescale 1ns/1ps

module tb_control_pipe;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned OCC_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [OCC_W-1:0] occupancy;
    logic             out_perr;

    int total = 0;
    int bad = 0;
    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] exp_w;

    control_pipe #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy),
        .out_perr  (out_perr)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge, so the negedge view is what the next edge transfers.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected_word got=%h want=none", out_data);
                end else begin
                    exp_w = sb.pop_front();
                    if (out_data !== exp_w) begin
                        bad++;
                        $display("FAIL sb_data got=%h want=%h", out_data, exp_w);
                    end
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(in_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        while ((out_valid !== 1'b0 || occupancy !== '0) && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (out_valid !== 1'b0 || occupancy !== '0) begin
            bad++;
            $display("FAIL drain_timeout got=occ%0d want=occ0", occupancy);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_leftover got=%0d want=0", sb.size());
        end
    endtask

    task automatic test_reset();
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data got=%h want=00", out_data); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL rst_occ got=%0d want=0", occupancy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        total++; if (out_perr !== 1'b0) begin bad++; $display("FAIL rst_perr got=%b want=0", out_perr); end
        tick();
        #1 rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_stream();
        tick();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_data = 8'(i);
            tick();
            if (i >= 3) begin
                total++; if (out_valid !== 1'b1 || out_data !== 8'(i - 2)) begin
                    bad++; $display("FAIL stream_out got=%b/%h want=1/%h", out_valid, out_data, 8'(i - 2));
                end
                total++; if (occupancy !== 2'd3) begin bad++; $display("FAIL stream_occ got=%0d want=3", occupancy); end
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready got=%b want=1", in_ready); end
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] words [3];
        words = '{8'hA5, 8'h5A, 8'hFF};
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = words[i];
            tick();
        end
        in_valid = 1'b0;
        #1;
        total++; if (occupancy !== 2'd3) begin bad++; $display("FAIL bp_occ got=%0d want=3", occupancy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b want=0", in_ready); end
        total++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin bad++; $display("FAIL bp_head got=%b/%h want=1/a5", out_valid, out_data); end
        tick();
        tick();
        total++; if (out_data !== 8'hA5 || occupancy !== 2'd3) begin bad++; $display("FAIL bp_hold got=%h/%0d want=a5/3", out_data, occupancy); end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_full_accept got=%b want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (out_data !== 8'h5A || occupancy !== 2'd3) begin bad++; $display("FAIL bp_swap got=%h/%0d want=5a/3", out_data, occupancy); end
        drain();
    endtask

    task automatic test_bubble();
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || occupancy !== 2'd1) begin bad++; $display("FAIL bubble_early got=%b/%0d want=0/1", out_valid, occupancy); end
        tick();
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin bad++; $display("FAIL bubble_out got=%b/%h want=1/3c", out_valid, out_data); end
        total++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin bad++; $display("FAIL bubble_state got=%0d/%b want=1/1", occupancy, in_ready); end
        drain();
    endtask

    task automatic test_flush();
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h21;
        tick();
        in_data = 8'h22;
        tick();
        in_data = 8'h77;
        flush   = 1'b1;
        #1;
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL flush_pre_occ got=%0d want=2", occupancy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", in_ready); end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        total++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_clear got=%0d/%b want=0/0", occupancy, out_valid); end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost got=%h want=none", out_data); end
        end
        // Full pipe flushed while the consumer takes the head word: that word still counts.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(8'h31 + i);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (occupancy !== 2'd0 || sb.size() != 0) begin bad++; $display("FAIL flush_deliver got=%0d/%0d want=0/0", occupancy, sb.size()); end
        drain();
    endtask

    task automatic test_async_reset();
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(8'h51 + i);
            tick();
        end
        in_valid = 1'b0;
        total++; if (occupancy !== 2'd3) begin bad++; $display("FAIL ar_pre_occ got=%0d want=3", occupancy); end
        #1 rst_n = 1'b0;
        sb.delete();
        #1;
        total++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin bad++; $display("FAIL ar_out got=%b/%h want=0/00", out_valid, out_data); end
        total++; if (occupancy !== 2'd0 || in_ready !== 1'b0) begin bad++; $display("FAIL ar_state got=%0d/%b want=0/0", occupancy, in_ready); end
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h42;
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ar_resume_ready got=%b want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_lat1 got=%b want=0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_lat2 got=%b want=0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 8'h42) begin bad++; $display("FAIL ar_lat3 got=%b/%h want=1/42", out_valid, out_data); end
        drain();
    endtask

    task automatic test_parity();
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h0F;
        tick();
        in_data = 8'h01;
        tick();
        in_valid = 1'b0;
        tick();
        total++; if (out_data !== 8'h0F || out_perr !== 1'b0) begin bad++; $display("FAIL par_clean got=%h/%b want=0f/0", out_data, out_perr); end
`ifdef CONTROL_PIPE_PARITY_EN
        force u_dut.g_stage[2].u_stage.data_q = 9'h10F;
        #1;
        total++; if (out_perr !== 1'b1) begin bad++; $display("FAIL par_detect got=%b want=1", out_perr); end
        release u_dut.g_stage[2].u_stage.data_q;
`else
        #1;
        total++; if (out_perr !== 1'b0) begin bad++; $display("FAIL par_off got=%b want=0", out_perr); end
`endif
        out_ready = 1'b1;
        tick();
        total++; if (out_data !== 8'h01 || out_perr !== 1'b0) begin bad++; $display("FAIL par_next got=%h/%b want=01/0", out_data, out_perr); end
        drain();
    endtask

    task automatic test_random();
        tick();
        for (int c = 0; c < 400; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom_range(0, 255));
            flush     = ($urandom_range(0, 39) == 0);
            tick();
            total++; if (int'(occupancy) != sb.size()) begin bad++; $display("FAIL rnd_occ got=%0d want=%0d", occupancy, sb.size()); end
            total++; if (out_perr !== 1'b0) begin bad++; $display("FAIL rnd_perr got=%b want=0", out_perr); end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_flush();
        test_async_reset();
        test_parity();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
